spi_ram_slave_p: RTL and testbench

- Parametrised SPI-style serial slave with an integrated single-port RAM; successor to the fixed 10-bit command slave.
- Decodes a 2-bit opcode plus an ADDR_W or DATA_W payload per frame. Holds separate write and read address pointers and shifts read data out on MISO.
- clk acts as the serial bit clock. One MOSI bit is sampled per rising clk edge while SS_n is low.

---
 rtl/spi_ram_slave_p.sv | 179 +++++++++++++++++
 tb/tb_spi_ram_slave_p.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_slave_p.sv
// Serial command slave with an integrated single-port RAM; 2-bit opcode then an address or data payload.
// Optional build macro SPI_AUTO_INC_EN: pointers post-increment (wrapping) after each in-range data access.
module spi_ram_slave_p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              addr_err,
  output logic              busy
);
  // state  | meaning
  // IDLE   | no frame; next low-SS_n edge samples opcode bit1
  // CMD    | samples opcode bit0 and branches
  // ADDR   | shifting in an address payload (WR_ADDR / RD_ADDR)
  // WDATA  | shifting in a data payload (WR_DATA)
  // RLOAD  | one edge: fetch RAM[rd_ptr], present its MSB on MISO
  // RSHIFT | present the remaining bits MSB first, then one idle edge
  // DONE   | frame complete; ignore MOSI until SS_n rises
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_RLOAD  = 3'd4;
  localparam logic [2:0] S_RSHIFT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int SW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW = $clog2(SW + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state;
  logic              op_hi;
  logic [CW-1:0]     cnt;
  logic [SW-2:0]     sh;
  logic [SW-1:0]     sh_nxt;
  logic [DATA_W-2:0] rd_sh;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic              wr_ok;
  logic              rd_ok;
  logic              last_bit;
  logic              wr_fire;

  function automatic logic in_range(input logic [ADDR_W-1:0] p);
    return {1'b0, p} < DEPTH_L;
  endfunction

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return ({1'b0, p} == DEPTH_L - 1'b1) ? '0 : p + ADDR_W'(1);
  endfunction

  assign sh_nxt    = {sh, MOSI};
  assign last_addr = sh_nxt[ADDR_W-1:0];
  assign last_data = sh_nxt[DATA_W-1:0];
  assign wr_ok     = in_range(wr_ptr);
  assign rd_ok     = in_range(rd_ptr);
  assign rdata     = rd_ok ? mem[rd_ptr[IW-1:0]] : '0;
  assign last_bit  = (cnt == '0);
  assign wr_fire   = !SS_n && (state == S_WDATA) && last_bit && wr_ok;
  assign busy      = (state != S_IDLE);

  // RAM contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[IW-1:0]] <= last_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_hi    <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      rd_sh    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      MISO     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      addr_err <= 1'b0;
      if (SS_n) begin
        state <= S_IDLE;
        MISO  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            op_hi <= MOSI;
            MISO  <= 1'b0;
            state <= S_CMD;
          end
          S_CMD: begin
            case ({op_hi, MOSI})
              2'b01: begin
                cnt   <= CW'(DATA_W - 1);
                state <= S_WDATA;
              end
              2'b11: state <= S_RLOAD;
              default: begin
                cnt   <= CW'(ADDR_W - 1);
                state <= S_ADDR;
              end
            endcase
          end
          S_ADDR: begin
            sh  <= sh_nxt[SW-2:0];
            cnt <= cnt - 1'b1;
            if (last_bit) begin
              state <= S_DONE;
              if (in_range(last_addr)) begin
                if (op_hi) rd_ptr <= last_addr;
                else       wr_ptr <= last_addr;
              end else begin
                addr_err <= 1'b1;
              end
            end
          end
          S_WDATA: begin
            sh  <= sh_nxt[SW-2:0];
            cnt <= cnt - 1'b1;
            if (last_bit) begin
              state <= S_DONE;
              if (wr_ok) begin
                rx_data  <= last_data;
                rx_valid <= 1'b1;
`ifdef SPI_AUTO_INC_EN
                wr_ptr   <= ptr_inc(wr_ptr);
`endif
              end else begin
                addr_err <= 1'b1;
              end
            end
          end
          S_RLOAD: begin
            rd_sh    <= rdata[DATA_W-2:0];
            MISO     <= rdata[DATA_W-1];
            cnt      <= CW'(DATA_W - 1);
            addr_err <= !rd_ok;
            state    <= S_RSHIFT;
          end
          S_RSHIFT: begin
            if (!last_bit) begin
              MISO  <= rd_sh[DATA_W-2];
              rd_sh <= rd_sh << 1;
              cnt   <= cnt - 1'b1;
            end else begin
              MISO  <= 1'b0;
              state <= S_DONE;
`ifdef SPI_AUTO_INC_EN
              if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
`endif
            end
          end
          S_DONE:  MISO  <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifndef SPI_AUTO_INC_EN
  logic unused_inc;
  assign unused_inc = ^ptr_inc(wr_ptr);
`endif

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed bench for spi_ram_slave_p: three instances (DEPTH 256, 200, 4) share clk/rst_n/MOSI, each with its own SS_n.
module tb_spi_ram_slave_p;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ss_n_v;
  logic       mosi;
  logic [2:0] miso_v, rxv_v, aerr_v, busy_v;
  logic [7:0] rxd_v [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_ram_slave_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) u_d256 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_v[0]), .MOSI(mosi), .MISO(miso_v[0]),
    .rx_data(rxd_v[0]), .rx_valid(rxv_v[0]), .addr_err(aerr_v[0]), .busy(busy_v[0]));
  spi_ram_slave_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(200)) u_d200 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_v[1]), .MOSI(mosi), .MISO(miso_v[1]),
    .rx_data(rxd_v[1]), .rx_valid(rxv_v[1]), .addr_err(aerr_v[1]), .busy(busy_v[1]));
  spi_ram_slave_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_v[2]), .MOSI(mosi), .MISO(miso_v[2]),
    .rx_data(rxd_v[2]), .rx_valid(rxv_v[2]), .addr_err(aerr_v[2]), .busy(busy_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input int sel, input logic b);
    ss_n_v      = 3'b111;
    ss_n_v[sel] = 1'b0;
    mosi        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_end();
    ss_n_v = 3'b111;
    mosi   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [1:0] op, input logic [7:0] pl,
                      output logic rv, output logic ae);
    clk_bit(sel, op[1]);
    clk_bit(sel, op[0]);
    for (int i = 7; i >= 0; i--) clk_bit(sel, pl[i]);
    rv = rxv_v[sel];
    ae = aerr_v[sel];
    frame_end();
  endtask

  task automatic rd_frame(input int sel, output logic [7:0] d, output logic ae,
                          output logic bsy, output logic tail);
    bsy = 1'b1;
    d   = '0;
    ae  = 1'b0;
    clk_bit(sel, 1'b1); bsy &= busy_v[sel];
    clk_bit(sel, 1'b1); bsy &= busy_v[sel];
    for (int i = 0; i < 8; i++) begin
      clk_bit(sel, 1'b0);
      if (i == 0) ae = aerr_v[sel];
      d = {d[6:0], miso_v[sel]};
      bsy &= busy_v[sel];
    end
    clk_bit(sel, 1'b0);
    tail = miso_v[sel];
    bsy &= busy_v[sel];
    frame_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       rv, ae, bsy, tail, seen;
    logic [7:0] d;

    rst_n  = 1'b0;
    ss_n_v = 3'b111;
    mosi   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_miso",     miso_v[0], 1'b0);
    check("rst_busy",     busy_v,    3'b000);
    check("rst_rx_valid", rxv_v[0],  1'b0);
    check("rst_addr_err", aerr_v[0], 1'b0);
    check("rst_rx_data",  rxd_v[0],  8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic write of 0xA7 to address 5
    send(0, 2'b00, 8'h05, rv, ae);
    check("wa5_rv", rv, 1'b0);
    check("wa5_ae", ae, 1'b0);
    send(0, 2'b01, 8'hA7, rv, ae);
    check("wd_a7_rv", rv, 1'b1);
    check("wd_a7_ae", ae, 1'b0);
    check("wd_a7_rx_data", rxd_v[0], 8'hA7);
    check("wd_a7_rv_pulse_end", rxv_v[0], 1'b0);

    // read it back
    send(0, 2'b10, 8'h05, rv, ae);
    check("ra5_ae", ae, 1'b0);
    rd_frame(0, d, ae, bsy, tail);
    check("rd_a7_data", d, 8'hA7);
    check("rd_a7_ae", ae, 1'b0);
    check("rd_a7_busy", bsy, 1'b1);
    check("rd_a7_tail", tail, 1'b0);

    // abort a WR_DATA frame after 4 of 8 data bits
    send(0, 2'b00, 8'h05, rv, ae);
    seen = 1'b0;
    clk_bit(0, 1'b0);
    clk_bit(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      clk_bit(0, 1'b1);
      seen |= rxv_v[0];
    end
    frame_end();
    seen |= rxv_v[0];
    check("abort_rv", seen, 1'b0);
    check("abort_idle", busy_v[0], 1'b0);
    send(0, 2'b10, 8'h05, rv, ae);
    rd_frame(0, d, ae, bsy, tail);
    check("abort_ram_kept", d, 8'hA7);
    send(0, 2'b01, 8'h3C, rv, ae);
    check("post_abort_rv", rv, 1'b1);
    check("post_abort_rx_data", rxd_v[0], 8'h3C);
    send(0, 2'b10, 8'h05, rv, ae);
    rd_frame(0, d, ae, bsy, tail);
    check("post_abort_rd", d, 8'h3C);

    // reset in the middle of RSHIFT
    send(0, 2'b00, 8'h00, rv, ae);
    send(0, 2'b01, 8'h5A, rv, ae);
    send(0, 2'b00, 8'h09, rv, ae);
    send(0, 2'b10, 8'h05, rv, ae);
    clk_bit(0, 1'b1);
    clk_bit(0, 1'b1);
    clk_bit(0, 1'b0);
    clk_bit(0, 1'b0);
    clk_bit(0, 1'b0);
    check("mid_rshift_bit5", miso_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", miso_v[0], 1'b0);
    check("rst_mid_busy", busy_v[0], 1'b0);
    #3;
    rst_n  = 1'b1;
    ss_n_v = 3'b111;
    @(posedge clk);
    #1;
    rd_frame(0, d, ae, bsy, tail);
    check("rst_rd_ptr0", d, 8'h5A);
    send(0, 2'b01, 8'h66, rv, ae);
    check("rst_wr_ptr0_rv", rv, 1'b1);
    send(0, 2'b10, 8'h00, rv, ae);
    rd_frame(0, d, ae, bsy, tail);
    check("rst_wr_ptr0_ram", d, 8'h66);

    // DEPTH=200 range errors
    send(1, 2'b00, 8'h10, rv, ae);
    check("d200_wa_ok_ae", ae, 1'b0);
    send(1, 2'b00, 8'hF0, rv, ae);
    check("d200_wa_oor_ae", ae, 1'b1);
    check("d200_wa_oor_rv", rv, 1'b0);
    check("d200_ae_pulse_end", aerr_v[1], 1'b0);
    send(1, 2'b01, 8'h11, rv, ae);
    check("d200_wd_rv", rv, 1'b1);
    check("d200_wd_ae", ae, 1'b0);
    send(1, 2'b10, 8'h10, rv, ae);
    send(1, 2'b10, 8'hF0, rv, ae);
    check("d200_ra_oor_ae", ae, 1'b1);
    rd_frame(1, d, ae, bsy, tail);
    check("d200_old_ptr_data", d, 8'h11);
    check("d200_old_ptr_ae", ae, 1'b0);

    // DEPTH=4 pointer behaviour
    send(2, 2'b00, 8'h04, rv, ae);
    check("d4_wa4_ae", ae, 1'b1);
    send(2, 2'b00, 8'h03, rv, ae);
    check("d4_wa3_ae", ae, 1'b0);
    send(2, 2'b01, 8'h11, rv, ae);
    check("d4_w11_rv", rv, 1'b1);
    send(2, 2'b01, 8'h22, rv, ae);
    check("d4_w22_rv", rv, 1'b1);
    send(2, 2'b10, 8'h03, rv, ae);
    rd_frame(2, d, ae, bsy, tail);
`ifdef SPI_AUTO_INC_EN
    check("d4_ram3", d, 8'h11);
    send(2, 2'b10, 8'h00, rv, ae);
    rd_frame(2, d, ae, bsy, tail);
    check("d4_ram0_wrap", d, 8'h22);
`else
    check("d4_ram3", d, 8'h22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
